// File: rtl/link_sprite_sequencer.sv
// link_sprite_sequencer
// Player-sprite sequencer sitting between the VGA scan counters and the
// sprite ROM/palette stage.
//   - Tracks facing direction, walk animation and the four-step sword attack,
//     advancing only on frame ticks.
//   - Registers a 5-bit sprite image id that changes only on a frame tick.
//   - Turns the scan position into a sprite-ROM pixel address.
//   - Delays the in-sprite flag so that it lines up with ROM data.
//
// Build option: define SPRITE_ATTACK_EN to include the ATTACK state and the
// step sequencing. Without it, attack_req is ignored, attacking is tied to 0
// and sprite_id[4:3] is always 00.
//
// Ports
//   Clk, Reset            clock; synchronous active-high reset
//   frame_tick            one-cycle pulse per video frame
//   dir, moving           requested direction (00 up, 01 down, 10 left, 11 right) and move level
//   attack_req            sword button level
//   pos_x, pos_y          sprite top-left corner in screen pixels
//   DrawX, DrawY          current scan position
//   rom_addr              sprite-ROM pixel address (registered)
//   sprite_id             selected image
//   sprite_hit            ROM output pixel this cycle belongs to the sprite
//   attacking             attack sequence active
//   dir_latched           committed facing direction
module link_sprite_sequencer #(
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 32,
    parameter int WALK_DIV   = 8,
    parameter int ATTACK_DIV = 4,
    parameter int ROM_LAT    = 1,
    localparam int AW        = $clog2(SPRITE_W * SPRITE_H)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          frame_tick,
    input  logic [1:0]    dir,
    input  logic          moving,
    input  logic          attack_req,
    input  logic [9:0]    pos_x,
    input  logic [9:0]    pos_y,
    input  logic [9:0]    DrawX,
    input  logic [9:0]    DrawY,
    output logic [AW-1:0] rom_addr,
    output logic [4:0]    sprite_id,
    output logic          sprite_hit,
    output logic          attacking,
    output logic [1:0]    dir_latched
);
    localparam int XB  = $clog2(SPRITE_W);
    localparam int YB  = $clog2(SPRITE_H);
    localparam int WCW = (WALK_DIV > 1) ? $clog2(WALK_DIV) : 1;
    localparam logic [WCW-1:0] WC_MAX = WCW'(WALK_DIV - 1);

`ifdef SPRITE_ATTACK_EN
    localparam int ACW = (ATTACK_DIV > 1) ? $clog2(ATTACK_DIV) : 1;
    localparam logic [ACW-1:0] AC_MAX = ACW'(ATTACK_DIV - 1);
    typedef enum logic [1:0] {IDLE, WALK, ATTACK} state_t;
    logic [1:0]     step, step_nx;
    logic [ACW-1:0] acnt, acnt_nx;
    logic           atk_done;
`else
    typedef enum logic {IDLE, WALK} state_t;
    logic unused_attack_req;
    assign unused_attack_req = attack_req;
`endif

    state_t         state, state_nx;
    logic [WCW-1:0] wcnt, wcnt_nx;
    logic           walk_ph, ph_nx;
    logic [1:0]     dir_nx;
    logic [4:0]     sid_nx;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk) begin
        if (Reset)           state <= IDLE;
        else if (frame_tick) state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
`ifdef SPRITE_ATTACK_EN
    assign atk_done = (step == 2'd3) && (acnt == AC_MAX);
`endif

    always_comb begin
        state_nx = state;
        case (state)
`ifdef SPRITE_ATTACK_EN
            IDLE:    if (attack_req) state_nx = ATTACK;
                     else if (moving) state_nx = WALK;
            WALK:    if (attack_req) state_nx = ATTACK;
                     else if (!moving) state_nx = IDLE;
            // attack_req is not looked at here; a held button re-triggers
            // from IDLE/WALK on the following tick.
            ATTACK:  if (atk_done) state_nx = moving ? WALK : IDLE;
`else
            IDLE:    if (moving) state_nx = WALK;
            WALK:    if (!moving) state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- FSM: outputs and per-tick next values ----------------
    always_comb begin
        dir_nx  = dir;
        wcnt_nx = wcnt;
        ph_nx   = walk_ph;
`ifdef SPRITE_ATTACK_EN
        attacking = (state == ATTACK);
        step_nx   = 2'd0;            // outside ATTACK the step logic sits at 0,
        acnt_nx   = '0;              // so entry always starts from step 0
        if (state == ATTACK) begin
            dir_nx = dir_latched;    // facing frozen for the whole attack
            if (acnt == AC_MAX) begin
                step_nx = step + 2'd1;
            end else begin
                step_nx = step;
                acnt_nx = acnt + 1'b1;
            end
        end
`else
        attacking = 1'b0;
`endif
        if (state_nx == IDLE) begin
            wcnt_nx = '0;
            ph_nx   = 1'b0;
`ifdef SPRITE_ATTACK_EN
        end else if (state_nx == ATTACK) begin
            if (state != ATTACK) wcnt_nx = '0;
`endif
        end else if (state == WALK) begin
            // only ticks spent in WALK advance the animation
            if (wcnt == WC_MAX) begin
                wcnt_nx = '0;
                ph_nx   = ~walk_ph;
            end else begin
                wcnt_nx = wcnt + 1'b1;
            end
        end
        // image id is built from the post-tick values so it matches the new state
        sid_nx = {2'b00, dir_nx, ph_nx};
`ifdef SPRITE_ATTACK_EN
        if (state_nx == ATTACK) sid_nx = {1'b1, dir_nx, step_nx};
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            dir_latched <= 2'b01;
            wcnt        <= '0;
            walk_ph     <= 1'b0;
            sprite_id   <= 5'd2;
`ifdef SPRITE_ATTACK_EN
            step        <= 2'd0;
            acnt        <= '0;
`endif
        end else if (frame_tick) begin
            dir_latched <= dir_nx;
            wcnt        <= wcnt_nx;
            walk_ph     <= ph_nx;
            sprite_id   <= sid_nx;
`ifdef SPRITE_ATTACK_EN
            step        <= step_nx;
            acnt        <= acnt_nx;
`endif
        end
    end

    // ---------------- address path ----------------
    // Zero-extended 11-bit difference: bit 10 set means the scan is left of /
    // above the sprite; screen-edge overhang needs no special handling.
    logic [10:0]      rel_x, rel_y;
    logic             hit0;
    logic [ROM_LAT:0] hit_pipe;

    assign rel_x = {1'b0, DrawX} - {1'b0, pos_x};
    assign rel_y = {1'b0, DrawY} - {1'b0, pos_y};
    assign hit0  = !rel_x[10] && (rel_x < 11'(SPRITE_W)) &&
                   !rel_y[10] && (rel_y < 11'(SPRITE_H));

    // hit_pipe[0] is aligned with rom_addr; hit_pipe[ROM_LAT] with ROM data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr <= '0;
            hit_pipe <= '0;
        end else begin
            rom_addr <= hit0 ? {rel_y[YB-1:0], rel_x[XB-1:0]} : '0;
            hit_pipe <= {hit_pipe[ROM_LAT-1:0], hit0};
        end
    end

    assign sprite_hit = hit_pipe[ROM_LAT];

endmodule
